// File: rtl/bitrev_reorder.sv
// rtl/bitrev_reorder.sv - ping-pong reorder buffer turning bit-reversed FFT frames into natural order
// Bank {bank} is written in bit-reversed address order while {~bank} is read out in natural order.

module bitrev_reorder_ram #(
   parameter int AW = 4,
   parameter int W  = 36
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   // Read data is registered by the parent so its output flop can take the async reset.
   assign o_rdata = mem[i_raddr];

endmodule

module bitrev_reorder #(
   parameter int LGSIZE = 12,
   parameter int WIDTH  = 36
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clk_enable,
   input  logic             i_sync,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_sync
);

   logic [LGSIZE-1:0] wcnt_q, wcnt_d;
   logic              bank_q, bank_d;
   logic              wait_for_sync_q, wait_for_sync_d;
   logic              frame_ready_q, frame_ready_d;
   logic [WIDTH-1:0]  o_data_q, o_data_d;
   logic              o_sync_q, o_sync_d;

   logic              wr_en;
   logic [LGSIZE:0]   wr_addr;
   logic [LGSIZE:0]   rd_addr;
   logic [WIDTH-1:0]  rd_data;

   function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
      logic [LGSIZE-1:0] r;
      for (int i = 0; i < LGSIZE; i++) begin
         r[i] = v[LGSIZE-1-i];
      end
      return r;
   endfunction

   // While hunting for sync, wcnt is 0, so the sync sample lands at bitrev(0).
   assign wr_en   = i_clk_enable && (!wait_for_sync_q || i_sync);
   assign wr_addr = {bank_q, bitrev(wcnt_q)};
   assign rd_addr = {~bank_q, wcnt_q};

   bitrev_reorder_ram #(
      .AW (LGSIZE + 1),
      .W  (WIDTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (wr_en),
      .i_waddr (wr_addr),
      .i_wdata (i_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

   always_comb begin
      wcnt_d          = wcnt_q;
      bank_d          = bank_q;
      wait_for_sync_d = wait_for_sync_q;
      frame_ready_d   = frame_ready_q;
      o_data_d        = o_data_q;
      o_sync_d        = o_sync_q;
      if (i_clk_enable) begin
         o_data_d = frame_ready_q ? rd_data : '0;
         o_sync_d = frame_ready_q && (wcnt_q == '0) && !wait_for_sync_q;
         if (wr_en) begin
            wcnt_d          = wcnt_q + 1'b1;
            wait_for_sync_d = 1'b0;
            if (&wcnt_q) begin
               bank_d        = ~bank_q;
               frame_ready_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wcnt_q          <= '0;
         bank_q          <= 1'b0;
         wait_for_sync_q <= 1'b1;
         frame_ready_q   <= 1'b0;
         o_data_q        <= '0;
         o_sync_q        <= 1'b0;
      end else begin
         wcnt_q          <= wcnt_d;
         bank_q          <= bank_d;
         wait_for_sync_q <= wait_for_sync_d;
         frame_ready_q   <= frame_ready_d;
         o_data_q        <= o_data_d;
         o_sync_q        <= o_sync_d;
      end
   end

   assign o_data = o_data_q;
   assign o_sync = o_sync_q;

endmodule

// File: tb/tb_bitrev_reorder.sv
// tb/tb_bitrev_reorder.sv - scoreboard bench for bitrev_reorder with N=8 directed frames

module tb_bitrev_reorder;

   localparam int LG = 3;
   localparam int W  = 36;

   logic          i_clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_clk_enable = 1'b0;
   logic          i_sync = 1'b0;
   logic [W-1:0]  i_data = '0;
   logic [W-1:0]  o_data;
   logic          o_sync;

   typedef struct packed {
      logic         s;
      logic [W-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   nat [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   always #5 i_clk = ~i_clk;

   bitrev_reorder #(.LGSIZE(LG), .WIDTH(W)) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_clk_enable (i_clk_enable),
      .i_sync       (i_sync),
      .i_data       (i_data),
      .o_data       (o_data),
      .o_sync       (o_sync)
   );

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      r = {4'($urandom), $urandom};
      return r;
   endfunction

   task automatic step(input logic en, input logic s, input logic [W-1:0] d,
                       input logic es, input logic [W-1:0] ed);
      exp_t e;
      @(negedge i_clk);
      i_clk_enable = en;
      i_sync       = s;
      i_data       = d;
      e.s = es;
      e.d = ed;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      #2;
      i_reset_n    = 1'b0;
      i_clk_enable = 1'b0;
      i_sync       = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      check("reset_o_data", o_data, '0);
      check("reset_o_sync", {35'd0, o_sync}, '0);
   endtask

   // Three frames: 0..7 (sync), 100..107, 50..57; optional extra sync at k=extra_k
   // and optional disabled cycle after every enabled one.
   task automatic run_frames(input int extra_k, input bit alt_en);
      logic         s, es;
      logic [W-1:0] d, ed;
      int           k, f;
      if (alt_en) step(1'b0, 1'b1, 36'd99, 1'b0, '0);
      for (int i = 0; i < 24; i++) begin
         k = i % 8;
         f = i / 8;
         s = (i == 0) || (extra_k >= 0 && k == extra_k);
         d = (f == 0) ? W'(k) : (f == 1) ? W'(100 + k) : W'(50 + k);
         es = (f != 0) && (k == 0);
         ed = (f == 0) ? '0 : (f == 1) ? W'(nat[k]) : W'(100 + nat[k]);
         step(1'b1, s, d, es, ed);
         if (alt_en) step(1'b0, 1'b0, rnd(), es, ed);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (o_sync !== e.s || o_data !== e.d) begin
               n_bad++;
               $display("FAIL out: got sync=%0b data=%0d, want sync=%0b data=%0d",
                        o_sync, o_data, e.s, e.d);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      // 1: no sync, output stays zero
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, rnd(), 1'b0, '0);

      // 2+3: single sync, back-to-back frames
      do_reset();
      run_frames(-1, 1'b0);

      // 4: enable toggling every cycle
      do_reset();
      run_frames(-1, 1'b1);

      // 5: stray sync at k=3 is ignored
      do_reset();
      run_frames(3, 1'b0);

      // 6: async reset mid-frame
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, k == 0, W'(10 + k), 1'b0, '0);
      step(1'b1, 1'b0, 36'd30, 1'b1, 36'd10);
      @(posedge i_clk);
      #3;
      i_reset_n = 1'b0;
      #1;
      check("async_rst_o_data", o_data, '0);
      check("async_rst_o_sync", {35'd0, o_sync}, '0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, W'(40 + k), 1'b0, '0);
      for (int k = 0; k < 8; k++) step(1'b1, k == 0, W'(20 + k), 1'b0, '0);
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, '0, k == 0, W'(20 + nat[k]));

      @(posedge i_clk);
      #2;
      check("queue_drained", W'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
